// File: rtl/multicycle_control.sv
// Multicycle control FSM for the MIPS-style core.
// Sequences fetch / decode / execute / memory / writeback, drives datapath
// enables and mux selects, handshakes with a variable-latency memory,
// counts retired instructions and traps on unsupported opcodes.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAddr = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRExec   = 4'd7,
    StRWb     = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StIExec   = 4'd11,
    StIWb     = 4'd12,
    StTrap    = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpAddi  = 6'h08;

  state_e           state_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             retire;
  state_e           after_retire;

  // Instruction completes this cycle; pick where the FSM goes afterwards.
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      StMemWb, StRWb, StBranch, StJump, StIWb: retire = 1'b1;
      StMemWr:                                 retire = mem_ready;
      default:                                 retire = 1'b0;
    endcase
    after_retire = run ? StFetch : StIdle;
  end

  // State register, retired counter and sticky trap flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      case (state_q)
        StIdle: begin
          if (run) state_q <= StFetch;
        end
        StFetch: begin
          if (mem_ready) state_q <= StDecode;
        end
        StDecode: begin
          case (opcode)
            OpLw, OpSw: state_q <= StMemAddr;
            OpRtype:    state_q <= StRExec;
            OpBeq:      state_q <= StBranch;
            OpJ:        state_q <= StJump;
            OpAddi:     state_q <= StIExec;
            default: begin
              state_q   <= StTrap;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // Only lw and sw reach here; IR is stable so opcode still tells them apart.
        StMemAddr: state_q <= (opcode == OpSw) ? StMemWr : StMemRd;
        StMemRd: begin
          if (mem_ready) state_q <= StMemWb;
        end
        StMemWr: begin
          if (mem_ready) state_q <= after_retire;
        end
        StRExec:  state_q <= StRWb;
        StIExec:  state_q <= StIWb;
        StMemWb, StRWb, StBranch, StJump, StIWb: state_q <= after_retire;
        // Absorbing until reset.
        StTrap:   state_q <= StTrap;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Control outputs decoded from the state register; only the FETCH and
  // BRANCH write pulses look at the live mem_ready / zero inputs.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'd3;
      end
      StMemAddr: begin
        alu_src_b = 2'd2;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StRExec: begin
        alu_op = 2'd2;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_op   = 2'd1;
        pc_src   = 2'd1;
        pc_write = zero;
      end
      StJump: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
      end
      StIExec: begin
        alu_src_b = 2'd2;
      end
      StIWb: begin
        reg_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

  // Read and write requests are mutually exclusive by construction.
  assert property (@(posedge clk) !(mem_read && mem_write));

  // The trap flag and the TRAP state always agree.
  assert property (@(posedge clk) illegal_q == (state_q == StTrap));

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control FSM for the MIPS-style core. It consumes the opcode field produced by the instruction decoder and sequences fetch, decode, execute, memory and writeback over several cycles. It drives the datapath enables and muxes, handshakes with a variable-latency memory, counts retired instructions, and traps on unsupported opcodes.

## Interface
Parameters:
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- run  input  1  permits starting a new instruction fetch.
- opcode  input  6  instruction[31:26] from the decoder; valid from DECODE onward (IR is stable).
- zero  input  1  ALU zero flag; sampled in BRANCH.
- mem_ready  input  1  memory completes the current read/write this cycle.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result register.
- ir_write  output  1  load instruction register.
- pc_write  output  1  load PC.
- pc_src  output  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target {PC[31:28], adr, 2'b00}.
- alu_src_b  output  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- alu_op  output  2  0 = add, 1 = subtract, 2 = use funct.
- reg_write  output  1  register-file write enable.
- reg_dst  output  1  destination: 0 = rt, 1 = rd.
- mem_to_reg  output  1  writeback data: 0 = ALU, 1 = memory data.
- illegal  output  1  sticky trap flag.
- state  output  4  current state encoding, for debug.
- retired  output  CNT_W  number of completed instructions.

## Operation
- Supported opcodes: 0x00 R-type, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j, 0x08 addi. Any other opcode is illegal.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, TRAP=13.
- IDLE: all outputs 0. Goes to FETCH when run=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_b=1, alu_op=0. Holds until mem_ready=1. In the cycle with mem_ready=1, ir_write=1, pc_write=1, pc_src=0, and the FSM moves to DECODE.
- DECODE: alu_src_b=3, alu_op=0 (precomputes the branch target). Next state depends on opcode:
  - lw or sw: MEM_ADDR.
  - R-type: R_EXEC.
  - beq: BRANCH.
  - j: JUMP.
  - addi: I_EXEC.
  - otherwise: TRAP.
- MEM_ADDR: alu_src_b=2, alu_op=0. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready. Ends the instruction on that cycle.
- R_EXEC: alu_src_b=0, alu_op=2.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- BRANCH: alu_src_b=0, alu_op=1, pc_src=1, pc_write=zero.
- JUMP: pc_src=2, pc_write=1.
- I_EXEC: alu_src_b=2, alu_op=0.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- Terminal states are MEM_WB, MEM_WR (with mem_ready), R_WB, BRANCH, JUMP and I_WB. On leaving a terminal state:
  - retired increments by 1; it wraps modulo 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
- run is ignored in every non-terminal state. An instruction in progress always completes.
- TRAP: illegal=1, all other outputs 0. TRAP is absorbing; only reset leaves it. A trapped instruction is not counted in retired.
- Any output not listed for a state is 0.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, retired=0, illegal=0. All outputs are 0 from the following cycle on. A reset mid-instruction or during a pending memory request abandons it; no output persists.
- Control outputs are decoded from the state register. mem_ready, zero and opcode affect only the gated pulses (ir_write, pc_write in FETCH and BRANCH) and the next state.
- Latency with zero-wait memory (mem_ready=1 whenever requested), counted from entering FETCH:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - addi: 4 cycles.
- Each cycle of mem_ready=0 during a memory request adds one cycle. Outputs stay constant while stalled.
- mem_read and mem_write are never asserted together.
- ir_write and pc_write pulse for exactly 1 cycle per event.

## Test plan
- Reset, then run=1, R-type opcode 0x00, mem_ready always 1. Required state sequence: 1, 2, 7, 8, 1. reg_write=1 with reg_dst=1 in cycle 4. retired=1 after that cycle.
- lw with mem_ready low for 3 cycles in both FETCH and MEM_RD. Required:
  - FETCH lasts 4 cycles and MEM_RD lasts 4 cycles.
  - ir_write is a single pulse on the 4th FETCH cycle.
  - mem_to_reg=1 in MEM_WB.
- beq twice, once with zero=1 and once with zero=0. Required: pc_write=1 with pc_src=1 in BRANCH only for zero=1. Both executions increment retired.
- Opcode 0x3F. Required: DECODE goes to TRAP, illegal=1 and stays set with run=1 for 10 cycles, retired is unchanged. Asserting rst_n=0 clears illegal and returns the FSM to IDLE.
- sw with run dropped to 0 during MEM_ADDR. Required: mem_write held until mem_ready, then the FSM goes to IDLE and stays there. Raising run resumes at FETCH.
- Preload retired to all-ones (force or CNT_W=4 with 15 instructions), then run one more j instruction. Required: retired wraps to 0.
